sleep_ctrl_mc: RTL and testbench
================================

# sleep_ctrl_mc

Parametrised multi-source sleep controller for the core clock domain. It is the next generation of the core sleep/clock-gating unit. It replaces the fixed-depth wake delay line with a programmable hold counter, and takes a maskable vector of wake sources instead of a single request. It adds per-source wake capture and a saturating sleep-cycle counter. It sits between the ungated system clock and the core, drives the glitch-free gated core clock, and produces the sticky fetch enable.

## Interface
Parameters:
- NUM_SRC, 4, number of wake sources (1..32)
- HOLD_W, 8, width of hold counter and hold_cfg_i
- CNT_W, 16, width of sleep-cycle counter

Ports:
- clk_ungated_i  in  1  free-running clock
- resetn  in  1  reset; asynchronous, active-low; clock is clk_ungated_i
- scan_cg_en_i  in  1  forces clock gate open (test)
- fetch_enable_i  in  1  fetch enable request; sticky once seen
- wake_src_i  in  NUM_SRC  level wake/busy requests
- wake_mask_i  in  NUM_SRC  1 = source ignored
- force_awake_i  in  1  keeps core awake, unmaskable
- hold_cfg_i  in  HOLD_W  idle cycles to hold clock after last activity
- wake_clr_i  in  1  clears wake_pending_o
- cnt_clr_i  in  1  clears sleep_cnt_o
- clk_gated_o  out  1  gated core clock
- fetch_enable_o  out  1  registered sticky fetch enable
- core_sleep_o  out  1  core is asleep
- core_busy_o  out  1  activity present or hold in progress
- state_o  out  2  FSM state: OFF=0, ACTIVE=1, SLEEP=2
- wake_pending_o  out  NUM_SRC  sources that caused or arrived during sleep
- sleep_cnt_o  out  CNT_W  cycles spent in SLEEP, saturating

## Operation
- act = |(wake_src_i & ~wake_mask_i) | force_awake_i. This signal is combinational.
- fetch_enable_q sets on the first edge where fetch_enable_i=1. Only reset clears it. fetch_enable_o = fetch_enable_q.
- FSM:
  - OFF: stay until fetch_enable_i=1. Then go to ACTIVE and load hold_cnt <= hold_cfg_i.
  - ACTIVE: if act, hold_cnt <= hold_cfg_i. Else if hold_cnt != 0, hold_cnt decrements. Else (hold_cnt=0 and !act), go to SLEEP.
  - SLEEP: if act, go to ACTIVE and load hold_cnt <= hold_cfg_i.
- hold_cfg_i is sampled only on load. Changing it mid-hold does not affect the count in progress.
- clock_en = (state==ACTIVE) | (state==SLEEP & act) | (state==OFF & fetch_enable_i).
- Clock gate: a latch is transparent while clk_ungated_i is low and captures clock_en | scan_cg_en_i. clk_gated_o = latch & clk_ungated_i. There is no glitch on en changes during the high phase.
- core_sleep_o = (state==SLEEP) & !act.
- core_busy_o = act | (state==ACTIVE & hold_cnt != 0).
- wake_pending_o[i] sets on an edge where state==SLEEP and wake_src_i[i] & ~wake_mask_i[i]. It clears on wake_clr_i. If set and clear coincide, set wins.
- sleep_cnt_o increments on each edge with state==SLEEP and saturates at all-ones. cnt_clr_i clears it and has priority over increment.

## Timing
- Reset values: state OFF, hold_cnt 0, fetch_enable_o 0, core_sleep_o 0, core_busy_o = act, wake_pending_o 0, sleep_cnt_o 0.
- clk_gated_o is low from the first low phase after reset assertion, unless scan_cg_en_i=1.
- Reset mid-hold or mid-sleep aborts immediately to the reset values. fetch_enable_i must be reasserted.
- fetch_enable_i high at edge E0:
  - fetch_enable_o=1 and state=ACTIVE after E0.
  - clk_gated_o pulses at E0 itself, because the en path is combinational.
- Sleep entry: let E be the last edge with act=1. There are hold_cfg_i decrement edges, then one transition edge. So clk_gated_o delivers exactly hold_cfg_i+1 rising edges after E, then stays low.
- hold_cfg_i=0: the SLEEP transition occurs on the first edge with act=0.
- Wake latency: act rising during the low phase before edge W means clk_gated_o pulses at W, and state=ACTIVE after W. This is zero cycles of latency.
- act toggling every cycle keeps reloading hold_cnt, so no sleep occurs.
- A masked source never wakes the core and never sets wake_pending_o.

## Test plan
- Reset, then fetch_enable_i=1 for one cycle, then 0 -> fetch_enable_o stays 1; state ACTIVE; with hold_cfg_i=3 and act=0, exactly 4 gated edges, then core_sleep_o=1 and state=2.
- In SLEEP, pulse wake_src_i[2]=1 for one cycle with hold_cfg_i=5 -> gated edge on that cycle, then 6 more gated edges; wake_pending_o=4'b0100; sleep_cnt_o equals cycles slept.
- wake_mask_i=4'b0100 and wake_src_i[2]=1 -> no clock edges, core_sleep_o stays 1, wake_pending_o stays 0; force_awake_i=1 -> clock runs continuously.
- CNT_W=4: sleep 20 cycles -> sleep_cnt_o=15. Assert cnt_clr_i and a wake-set together with wake_clr_i -> counter 0, wake bit remains 1.
- Assert resetn=0 mid-hold (hold_cnt=2) -> state OFF, all outputs at reset values, clk_gated_o low; scan_cg_en_i=1 -> clk_gated_o follows clk_ungated_i.
- Change hold_cfg_i from 3 to 10 during a hold countdown -> the current countdown still ends after 3; the next load uses 10.

Source files
------------

// File: rtl/sleep_ctrl_mc.sv
// Multi-source sleep controller: gates the core clock after a programmable idle hold,
// wakes on any unmasked source, captures wake causes and counts cycles spent asleep.
module sleep_ctrl_mc #(
    parameter int NUM_SRC = 4,
    parameter int HOLD_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk_ungated_i,
    input  logic               resetn,
    input  logic               scan_cg_en_i,
    input  logic               fetch_enable_i,
    input  logic [NUM_SRC-1:0] wake_src_i,
    input  logic [NUM_SRC-1:0] wake_mask_i,
    input  logic               force_awake_i,
    input  logic [HOLD_W-1:0]  hold_cfg_i,
    input  logic               wake_clr_i,
    input  logic               cnt_clr_i,
    output logic               clk_gated_o,
    output logic               fetch_enable_o,
    output logic               core_sleep_o,
    output logic               core_busy_o,
    output logic [1:0]         state_o,
    output logic [NUM_SRC-1:0] wake_pending_o,
    output logic [CNT_W-1:0]   sleep_cnt_o
);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_SLEEP  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic                fetch_enable_reg;
    logic [NUM_SRC-1:0]  wake_pending_reg;
    logic [CNT_W-1:0]    sleep_cnt_reg;
    logic [NUM_SRC-1:0]  src_hit;
    logic                act;
    logic                clock_en;
    logic                en_latch;

    assign src_hit = wake_src_i & ~wake_mask_i;
    assign act     = (|src_hit) | force_awake_i;

    always_ff @(posedge clk_ungated_i or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_OFF;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            ST_OFF: begin
                if (fetch_enable_i) begin
                    state_next    = ST_ACTIVE;
                    hold_cnt_next = hold_cfg_i;
                end
            end
            ST_ACTIVE: begin
                if (act) begin
                    hold_cnt_next = hold_cfg_i;
                end else if (hold_cnt_reg != '0) begin
                    hold_cnt_next = hold_cnt_reg - 1'b1;
                end else begin
                    state_next = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (act) begin
                    state_next    = ST_ACTIVE;
                    hold_cnt_next = hold_cfg_i;
                end
            end
            default: state_next = ST_OFF;
        endcase
    end

    always_ff @(posedge clk_ungated_i or negedge resetn) begin
        if (!resetn) begin
            fetch_enable_reg <= 1'b0;
        end else if (fetch_enable_i) begin
            fetch_enable_reg <= 1'b1;
        end
    end

    // Set beats clear so a cause arriving on the clearing edge is not lost.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pending
            always_ff @(posedge clk_ungated_i or negedge resetn) begin
                if (!resetn) begin
                    wake_pending_reg[gi] <= 1'b0;
                end else if (state_reg == ST_SLEEP && src_hit[gi]) begin
                    wake_pending_reg[gi] <= 1'b1;
                end else if (wake_clr_i) begin
                    wake_pending_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_ungated_i or negedge resetn) begin
        if (!resetn) begin
            sleep_cnt_reg <= '0;
        end else if (cnt_clr_i) begin
            sleep_cnt_reg <= '0;
        end else if (state_reg == ST_SLEEP && sleep_cnt_reg != {CNT_W{1'b1}}) begin
            sleep_cnt_reg <= sleep_cnt_reg + 1'b1;
        end
    end

    // Enable is combinational so a wake seen in the low phase opens the very next edge.
    assign clock_en = resetn & ((state_reg == ST_ACTIVE)
                             | (state_reg == ST_SLEEP & act)
                             | (state_reg == ST_OFF & fetch_enable_i));

    always_latch begin
        if (!clk_ungated_i) begin
            en_latch = clock_en | scan_cg_en_i;
        end
    end

    assign clk_gated_o    = en_latch & clk_ungated_i;
    assign fetch_enable_o = fetch_enable_reg;
    assign core_sleep_o   = (state_reg == ST_SLEEP) & ~act;
    assign core_busy_o    = act | ((state_reg == ST_ACTIVE) & (hold_cnt_reg != '0));
    assign state_o        = state_reg;
    assign wake_pending_o = wake_pending_reg;
    assign sleep_cnt_o    = sleep_cnt_reg;

endmodule

// File: tb/tb_sleep_ctrl_mc.sv
// Bench for sleep_ctrl_mc: directed scenarios, a per-cycle reference model of the
// idle/sleep behaviour, and literal checks on gated-edge counts and key outputs.
module tb_sleep_ctrl_mc;

    localparam int NS = 4;
    localparam int HW = 8;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          resetn;
    logic          scan_cg_en;
    logic          fetch_enable;
    logic [NS-1:0] wake_src;
    logic [NS-1:0] wake_mask;
    logic          force_awake;
    logic [HW-1:0] hold_cfg;
    logic          wake_clr;
    logic          cnt_clr;
    logic          clk_gated;
    logic          fetch_enable_q;
    logic          core_sleep;
    logic          core_busy;
    logic [1:0]    state;
    logic [NS-1:0] wake_pending;
    logic [CW-1:0] sleep_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int gcount   = 0;

    sleep_ctrl_mc #(.NUM_SRC(NS), .HOLD_W(HW), .CNT_W(CW)) dut (
        .clk_ungated_i  (clk),
        .resetn         (resetn),
        .scan_cg_en_i   (scan_cg_en),
        .fetch_enable_i (fetch_enable),
        .wake_src_i     (wake_src),
        .wake_mask_i    (wake_mask),
        .force_awake_i  (force_awake),
        .hold_cfg_i     (hold_cfg),
        .wake_clr_i     (wake_clr),
        .cnt_clr_i      (cnt_clr),
        .clk_gated_o    (clk_gated),
        .fetch_enable_o (fetch_enable_q),
        .core_sleep_o   (core_sleep),
        .core_busy_o    (core_busy),
        .state_o        (state),
        .wake_pending_o (wake_pending),
        .sleep_cnt_o    (sleep_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk_gated) gcount++;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: mode 0=off 1=active 2=asleep; idle edges counted against the loaded hold.
    int        m_mode, m_hold, m_idle, m_cnt, m_old;
    bit        m_fe;
    logic [NS-1:0] m_pend;
    bit        c_act, c_en;

    task automatic model_reset();
        m_mode = 0; m_hold = 0; m_idle = 0; m_cnt = 0; m_fe = 0; m_pend = '0;
    endtask

    task automatic model_step(input bit a);
        m_old = m_mode;
        if (fetch_enable) m_fe = 1;
        if (cnt_clr) m_cnt = 0;
        else if (m_old == 2 && m_cnt < CNT_MAX) m_cnt++;
        m_pend = (wake_clr ? '0 : m_pend) | ((m_old == 2) ? (wake_src & ~wake_mask) : '0);
        case (m_old)
            0: if (fetch_enable) begin m_mode = 1; m_hold = int'(hold_cfg); m_idle = 0; end
            1: begin
                if (a) begin m_hold = int'(hold_cfg); m_idle = 0; end
                else if (m_idle < m_hold) m_idle++;
                else m_mode = 2;
            end
            default: if (a) begin m_mode = 1; m_hold = int'(hold_cfg); m_idle = 0; end
        endcase
    endtask

    initial model_reset();

    always @(posedge clk) begin
        c_act = (|(wake_src & ~wake_mask)) | force_awake;
        if (!resetn) model_reset();
        c_en = scan_cg_en | (resetn && (m_mode == 1 || (m_mode == 2 && c_act) || (m_mode == 0 && fetch_enable)));
        if (resetn) model_step(c_act);
        #1;
        check("clk_gated", 32'(clk_gated), 32'(c_en));
        check("state", 32'(state), 32'(m_mode));
        check("fetch_enable_o", 32'(fetch_enable_q), 32'(m_fe));
        check("wake_pending", 32'(wake_pending), 32'(m_pend));
        check("sleep_cnt", 32'(sleep_cnt), 32'(m_cnt));
        check("core_sleep", 32'(core_sleep), 32'(m_mode == 2 && !c_act));
        check("core_busy", 32'(core_busy), 32'(c_act || (m_mode == 1 && m_hold != m_idle)));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_src(input logic [NS-1:0] v);
        wake_src = v;
        tick(1);
        wake_src = '0;
        gcount = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 0; scan_cg_en = 0; fetch_enable = 0; wake_src = '0; wake_mask = '0;
        force_awake = 0; hold_cfg = 8'd3; wake_clr = 0; cnt_clr = 0;
        tick(3);
        check("reset_state", 32'(state), 0);
        check("reset_fe", 32'(fetch_enable_q), 0);
        resetn = 1;
        tick(2);

        // Fetch enable pulse, then idle hold of 3 -> 4 gated edges then sleep.
        fetch_enable = 1;
        tick(1);
        fetch_enable = 0;
        gcount = 0;
        check("fe_sticky_active", 32'(state), 1);
        tick(10);
        $display("scenario fetch/hold3: gated edges=%0d state=%0d", gcount, state);
        check("hold3_edges", 32'(gcount), 4);
        check("hold3_state", 32'(state), 2);
        check("hold3_sleep", 32'(core_sleep), 1);
        check("fe_stays", 32'(fetch_enable_q), 1);

        // Count cleared, then 5 sleep cycles, then wake on source 2 with hold 5.
        cnt_clr = 1; tick(1); cnt_clr = 0;
        tick(5);
        check("sleep_cnt5", 32'(sleep_cnt), 5);
        hold_cfg = 8'd5;
        gcount = 0;
        wake_src = 4'b0100;
        tick(1);
        check("wake_edge", 32'(gcount), 1);
        wake_src = '0;
        tick(10);
        $display("scenario wake src2: gated edges=%0d pending=%b", gcount, wake_pending);
        check("wake_total_edges", 32'(gcount), 7);
        check("wake_pending_0100", 32'(wake_pending), 32'h4);

        // Masked source is ignored; force_awake keeps the clock running.
        hold_cfg = 8'd3;
        wake_clr = 1; tick(1); wake_clr = 0;
        wake_mask = 4'b0100; wake_src = 4'b0100; gcount = 0;
        tick(5);
        check("masked_edges", 32'(gcount), 0);
        check("masked_sleep", 32'(core_sleep), 1);
        check("masked_pending", 32'(wake_pending), 0);
        force_awake = 1; gcount = 0;
        tick(8);
        $display("scenario mask/force: gated edges under force=%0d", gcount);
        check("force_edges", 32'(gcount), 8);
        force_awake = 0; wake_src = '0; wake_mask = '0;
        tick(6);

        // Saturation of the 4-bit counter, then clear + set/clear collision.
        cnt_clr = 1; tick(1); cnt_clr = 0;
        tick(20);
        check("cnt_saturate", 32'(sleep_cnt), 15);
        cnt_clr = 1; wake_clr = 1; wake_src = 4'b0001;
        tick(1);
        cnt_clr = 0; wake_clr = 0; wake_src = '0;
        $display("scenario saturate/collide: cnt=%0d pending=%b", sleep_cnt, wake_pending);
        check("clr_cnt_zero", 32'(sleep_cnt), 0);
        check("set_beats_clr", 32'(wake_pending), 32'h1);
        tick(6);

        // hold_cfg change mid-countdown applies only at the next load.
        hold_cfg = 8'd3;
        pulse_src(4'b0010);
        hold_cfg = 8'd10;
        tick(8);
        check("hold_change_edges", 32'(gcount), 4);
        check("hold_change_state", 32'(state), 2);
        pulse_src(4'b0010);
        tick(15);
        $display("scenario hold change: edges after second wake=%0d", gcount);
        check("hold10_edges", 32'(gcount), 11);

        // Reset in the middle of a hold countdown.
        hold_cfg = 8'd3;
        pulse_src(4'b0001);
        tick(1);
        resetn = 0;
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_fe", 32'(fetch_enable_q), 0);
        check("rst_pending", 32'(wake_pending), 0);
        check("rst_cnt", 32'(sleep_cnt), 0);
        check("rst_sleep", 32'(core_sleep), 0);
        check("rst_busy", 32'(core_busy), 0);
        check("rst_gated_low", 32'(clk_gated), 0);
        gcount = 0;
        tick(4);
        check("rst_no_edges", 32'(gcount), 0);
        scan_cg_en = 1; gcount = 0;
        tick(4);
        $display("scenario reset/scan: gated edges with scan=%0d", gcount);
        check("scan_edges", 32'(gcount), 4);
        scan_cg_en = 0;
        resetn = 1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
